// File: rtl/pipe_out_buffer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipe_out_buffer_pkg                                                        |
// | Shared defaults and error-cause encoding for the pipe output buffer.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package pipe_out_buffer_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;
  localparam int unsigned DEFAULT_DEPTH = 8;

  typedef struct packed {
    logic issue_ovf;  // issue attempted with no credit left
    logic push_drop;  // result arrived with no free slot
  } err_cause_t;

  function automatic logic any_err(input err_cause_t c);
    return c.issue_ovf | c.push_drop;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_out_buffer_fifo_mem.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipe_out_buffer_fifo_mem                                                   |
// | DEPTH x WIDTH storage: one synchronous write port, one async read port.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pipe_out_buffer_fifo_mem #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  // No reset on the array so it maps onto fabric RAM.
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule
`default_nettype wire

// File: rtl/pipe_out_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipe_out_buffer                                                            |
// | Credit-issuing elastic FIFO behind a fixed-latency pipe, valid/ready out.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pipe_out_buffer
  import pipe_out_buffer_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  output logic             issue_ready,
  input  logic             issue,
  input  logic             pipe_valid,
  input  logic [WIDTH-1:0] pipe_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [AW:0]      count,
  output logic             err
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW:0]      credits_q, credits_d;
  logic [AW:0]      count_q, count_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             err_q, err_d;
  logic             issue_acc, pop_en, push_en;
  err_cause_t       cause;
  logic [WIDTH-1:0] rd_data;

  always_comb begin
    issue_acc = issue && (credits_q != '0);
    pop_en    = (count_q != '0) && out_ready;
    // A pop in the same cycle frees the slot the incoming word needs.
    push_en   = pipe_valid && ((count_q != FULL_CNT) || pop_en);

    cause.issue_ovf = issue && (credits_q == '0);
    cause.push_drop = pipe_valid && !push_en;
    err_d = err_q | any_err(cause);

    credits_d = credits_q;
    if (issue_acc && !pop_en) begin
      credits_d = credits_q - (AW+1)'(1);
    end else if (pop_en && !issue_acc && (credits_q != FULL_CNT)) begin
      credits_d = credits_q + (AW+1)'(1);
    end

    count_d = count_q;
    if (push_en && !pop_en) begin
      count_d = count_q + (AW+1)'(1);
    end else if (pop_en && !push_en) begin
      count_d = count_q - (AW+1)'(1);
    end

    wr_ptr_d = push_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_en  ? rd_ptr_q + AW'(1) : rd_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      credits_q <= FULL_CNT;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      credits_q <= credits_d;
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      err_q     <= err_d;
    end
  end

  pipe_out_buffer_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk       (clk),
    .wr_en_i   (push_en),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (pipe_data),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (rd_data)
  );

  assign issue_ready = (credits_q != '0);
  assign out_valid   = (count_q != '0);
  assign out_data    = out_valid ? rd_data : '0;
  assign count       = count_q;
  assign err         = err_q;

endmodule
`default_nettype wire
